fw_sample_loader: RTL and testbench

FW_SAMPLE_LOADER -- requirements
Module: fw_sample_loader

---
 rtl/fw_loader_pkg.sv | 20 ++
 rtl/fw_loader_fifo.sv | 59 +++++
 rtl/fw_sample_loader.sv | 112 +++++++++++
 tb/tb_fw_sample_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_loader_pkg.sv
// Shared types and default constants for the fuzzy-wavelet sample loader.
package fw_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fw_loader_fifo.sv
// Small synchronous FIFO with registered storage; pointers carry one extra
// wrap bit so full and empty are told apart without an occupancy counter.
module fw_loader_fifo
  import fw_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              ready
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_nxt;
  logic [AW:0]       rd_nxt;
  logic              full;
  logic              full_nxt;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign wr_nxt   = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_nxt   = rd_ptr + {{AW{1'b0}}, do_pop};
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  assign head     = mem[rd_ptr[AW-1:0]];

  // Pointer and ready registers; ready is the registered inverse of full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      ready  <= ~full_nxt;
    end
  end

  // Sample storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fw_sample_loader.sv
// Drains buffered host samples into the fuzzy wavelet one frame at a time:
// present the value, wait the setup time, pulse the load strobe, then hold.
module fw_sample_loader
  import fw_loader_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] o_value,
  output logic              o_data_clk,
  output logic              o_busy,
  output logic [7:0]        o_sent_count
);

  localparam int PH_W = $clog2(max2(SETUP_CYCLES, STROBE_CYCLES) + 1);
  localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LAST = PH_W'(STROBE_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [PH_W-1:0]   phase;
  logic              phase_done;
  logic              pop;
  logic              last_hold;
  logic              dclk_nxt;
  logic              empty;
  logic [DATA_W-1:0] head;

  fw_loader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .pop   (pop),
    .din   (s_data),
    .head  (head),
    .empty (empty),
    .ready (s_ready)
  );

  assign o_busy = (state != ST_IDLE) | ~empty;

  // Phase counter has reached the last cycle of the current timed state.
  always_comb begin
    phase_done = 1'b0;
    unique case (state)
      ST_SETUP:         phase_done = (phase == SETUP_LAST);
      ST_HIGH, ST_HOLD: phase_done = (phase == STROBE_LAST);
      default:          phase_done = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!empty)    state_nxt = ST_SETUP;
      ST_SETUP: if (phase_done) state_nxt = ST_HIGH;
      ST_HIGH:  if (phase_done) state_nxt = ST_HOLD;
      ST_HOLD:  if (phase_done) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: FIFO pop, frame completion and the next strobe level.
  always_comb begin
    pop       = (state == ST_IDLE) && !empty;
    last_hold = (state == ST_HOLD) && phase_done;
    dclk_nxt  = (state_nxt == ST_HIGH);
  end

  // Phase counter restarts on every state change and rests at zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst)                                       phase <= '0;
    else if (state_nxt != state || state == ST_IDLE) phase <= '0;
    else                                           phase <= phase + 1'b1;
  end

  // Strobe is a plain flop so the wavelet sees no combinational glitches.
  always_ff @(posedge clk) begin
    if (rst) o_data_clk <= 1'b0;
    else     o_data_clk <= dclk_nxt;
  end

  // Sample value is captured only on the edge that leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst)      o_value <= '0;
    else if (pop) o_value <= head;
  end

  // Completed-frame counter; wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst)            o_sent_count <= 8'd0;
    else if (last_hold) o_sent_count <= o_sent_count + 8'd1;
  end

endmodule

// File: tb/tb_fw_sample_loader.sv
// Bench for fw_sample_loader: table of single-frame vectors, hand sequences
// for streaming, back-pressure, reset and wrap, plus a scoreboard monitor.
module tb_fw_sample_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] o_value;
  logic       o_data_clk;
  logic       o_busy;
  logic [7:0] o_sent_count;

  logic       s_valid2;
  logic [7:0] s_data2;
  logic       s_ready2;
  logic [7:0] o_value2;
  logic       o_data_clk2;
  logic       o_busy2;
  logic [7:0] o_sent_count2;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb[$];
  logic [7:0] val_q[$];
  int         rise_q[$];

  always #5 clk = ~clk;

  fw_sample_loader u_dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .o_value      (o_value),
    .o_data_clk   (o_data_clk),
    .o_busy       (o_busy),
    .o_sent_count (o_sent_count)
  );

  fw_sample_loader #(
    .DATA_W        (8),
    .FIFO_DEPTH    (4),
    .SETUP_CYCLES  (3),
    .STROBE_CYCLES (1)
  ) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid2),
    .s_data       (s_data2),
    .s_ready      (s_ready2),
    .o_value      (o_value2),
    .o_data_clk   (o_data_clk2),
    .o_busy       (o_busy2),
    .o_sent_count (o_sent_count2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor on the falling edge, away from the active edge.
  logic       prev_dclk = 1'b0;
  logic [7:0] prev_val  = 8'd0;
  logic [7:0] rise_val  = 8'd0;
  logic [7:0] exp_v;
  int         high_cnt  = 0;
  int         age       = 0;
  int         cyc       = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      high_cnt  = 0;
      age       = 0;
      prev_val  = o_value;
      prev_dclk = o_data_clk;
    end else begin
      if (o_value != prev_val) age = 0;
      else                     age++;
      prev_val = o_value;
      if (o_data_clk && !prev_dclk) begin
        rise_q.push_back(cyc);
        val_q.push_back(o_value);
        rise_val = o_value;
        chk("setup_age", int'(age >= 1), 1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: strobe with value %0d, no sample queued", o_value);
        end else begin
          exp_v = sb.pop_front();
          chk("sb_value", int'(o_value), int'(exp_v));
        end
      end
      if (o_data_clk) high_cnt++;
      else if (prev_dclk && high_cnt > 0) begin
        chk("strobe_width", high_cnt, 2);
        chk("value_after_strobe", int'(o_value), int'(rise_val));
        high_cnt = 0;
      end
      prev_dclk = o_data_clk;
      if (s_valid && s_ready) sb.push_back(s_data);
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(o_busy), 0);
  endtask

  task automatic stream(input int n, input logic [7:0] base, output int saw_block);
    int   idx;
    int   guard;
    logic r;
    idx = 0;
    guard = 0;
    saw_block = 0;
    while (idx < n && guard < 5000) begin
      r       = s_ready;
      s_valid = 1'b1;
      s_data  = 8'(int'(base) + idx);
      step();
      if (r) idx++;
      else   saw_block = 1;
      guard++;
    end
    s_valid = 1'b0;
    chk("stream_accepted", idx, n);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt0;
    int blk;
    int n;
    logic exp_d2[6];

    vecs[0] = '{8'hA5, 8'd1};
    vecs[1] = '{8'h00, 8'd2};
    vecs[2] = '{8'hFF, 8'd3};
    vecs[3] = '{8'h5A, 8'd4};

    rst = 1'b1; s_valid = 1'b0; s_data = 8'd0;
    s_valid2 = 1'b0; s_data2 = 8'd0;
    repeat (3) step();
    chk("rst_value", int'(o_value), 0);
    chk("rst_dclk", int'(o_data_clk), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_count", int'(o_sent_count), 0);
    chk("rst_ready", int'(s_ready), 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", int'(s_ready), 1);

    // Single-frame vectors with exact cycle timing.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = vecs[i].din;
      step();
      s_valid = 1'b0;
      chk("vec_busy", int'(o_busy), 1);
      step();
      chk("vec_value", int'(o_value), int'(vecs[i].din));
      chk("vec_dclk_setup", int'(o_data_clk), 0);
      step(); chk("vec_dclk_h1", int'(o_data_clk), 1);
      step(); chk("vec_dclk_h2", int'(o_data_clk), 1);
      step(); chk("vec_dclk_hold", int'(o_data_clk), 0);
      step(); chk("vec_count_pre", int'(o_sent_count), int'(vecs[i].exp_cnt) - 1);
      step(); chk("vec_count", int'(o_sent_count), int'(vecs[i].exp_cnt));
      chk("vec_idle", int'(o_busy), 0);
    end

    // Back-to-back frames.
    cnt0 = int'(o_sent_count);
    rise_q.delete(); val_q.delete();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_ready", int'(s_ready), 1);
      s_valid = 1'b1; s_data = 8'(i + 1);
      step();
    end
    s_valid = 1'b0;
    wait_idle("b2b_idle", 100);
    chk("b2b_pulses", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size(); i++) chk("b2b_spacing", rise_q[i] - rise_q[i-1], 6);
    for (int i = 0; i < val_q.size(); i++) chk("b2b_order", int'(val_q[i]), i + 1);
    chk("b2b_count", int'(o_sent_count), (cnt0 + 4) % 256);

    // Back-pressure with eight samples offered continuously.
    cnt0 = int'(o_sent_count);
    val_q.delete();
    stream(8, 8'h10, blk);
    chk("full_blocked", blk, 1);
    wait_idle("full_idle", 200);
    chk("full_count", int'(o_sent_count), (cnt0 + 8) % 256);
    chk("full_frames", val_q.size(), 8);
    for (int i = 0; i < val_q.size(); i++) chk("full_order", int'(val_q[i]), 16 + i);
    chk("full_sb_empty", sb.size(), 0);

    // Reset while the strobe is high.
    s_valid = 1'b1; s_data = 8'h77;
    step();
    s_valid = 1'b0;
    n = 0;
    while (!o_data_clk && n < 20) begin step(); n++; end
    chk("reached_high", int'(o_data_clk), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rsth_dclk", int'(o_data_clk), 0);
    chk("rsth_count", int'(o_sent_count), 0);
    chk("rsth_busy", int'(o_busy), 0);
    step();
    chk("rsth_ready", int'(s_ready), 1);
    val_q.delete();
    s_valid = 1'b1; s_data = 8'h3C;
    step();
    s_valid = 1'b0;
    wait_idle("rsth_idle", 50);
    chk("rsth_after_count", int'(o_sent_count), 1);
    chk("rsth_after_frames", val_q.size(), 1);
    if (val_q.size() > 0) chk("rsth_after_value", int'(val_q[0]), 8'h3C);

    // Frame counter wrap.
    rst = 1'b1; step(); rst = 1'b0; step();
    stream(256, 8'h00, blk);
    wait_idle("wrap_idle", 100);
    chk("wrap_count", int'(o_sent_count), 0);
    stream(1, 8'hC3, blk);
    wait_idle("wrap1_idle", 50);
    chk("wrap1_count", int'(o_sent_count), 1);

    // Alternate timing: three setup cycles, one-cycle strobe.
    exp_d2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    chk("p2_start_count", int'(o_sent_count2), 0);
    s_valid2 = 1'b1; s_data2 = 8'hFF;
    step();
    s_valid2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p2_value", int'(o_value2), 8'hFF);
      chk("p2_dclk", int'(o_data_clk2), int'(exp_d2[i]));
      if (i == 4) chk("p2_count_pre", int'(o_sent_count2), 0);
    end
    chk("p2_count", int'(o_sent_count2), 1);
    chk("p2_idle", int'(o_busy2), 0);

    chk("sb_final_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
